// File: rtl/weight_feeder_pkg.sv
// Shared sizing defaults, feeder state encoding and a pointer-width helper
// for the double-buffered weight feeder.
package weight_feeder_pkg;

    localparam int DATA_SIZE = 8;
    localparam int MAC_WIDTH = 8;
    localparam int ROW_W     = MAC_WIDTH * DATA_SIZE;
    localparam int TILE_W    = MAC_WIDTH * MAC_WIDTH * DATA_SIZE;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } feed_state_e;

    // Row pointer width; a single-row matrix still needs a 1-bit pointer
    function automatic int ptr_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/weight_row_buffer.sv
// Load-side tile register: one row written per cycle by index, whole tile
// read in parallel for the swap into the active register.
module weight_row_buffer #(
    parameter int DATA_SIZE = weight_feeder_pkg::DATA_SIZE,
    parameter int MAC_WIDTH = weight_feeder_pkg::MAC_WIDTH,
    localparam int PTR_W    = weight_feeder_pkg::ptr_width(MAC_WIDTH),
    localparam int ROW_BITS = MAC_WIDTH * DATA_SIZE
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [PTR_W-1:0]                   wr_row,
    input  logic [ROW_BITS-1:0]                wr_data,
    output logic [MAC_WIDTH*ROW_BITS-1:0]      tile_out
);

    logic [ROW_BITS-1:0] rows_q [MAC_WIDTH];
    logic [ROW_BITS-1:0] rows_d [MAC_WIDTH];

    always_comb begin
        rows_d = rows_q;
        if (wr_en) begin
            rows_d[wr_row] = wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rows_q <= '{default: '0};
        end else begin
            rows_q <= rows_d;
        end
    end

    // Row r occupies cells (r,0..MAC_WIDTH-1), which are contiguous in the tile
    always_comb begin
        tile_out = '0;
        for (int r = 0; r < MAC_WIDTH; r++) begin
            tile_out[r*ROW_BITS +: ROW_BITS] = rows_q[r];
        end
    end

endmodule

// File: rtl/weight_feeder.sv
// Double-buffered weight tile feeder for mac_matrix: rows fill a load buffer,
// a full-matrix request swaps it into the registered active tile.
module weight_feeder #(
    parameter int DATA_SIZE = weight_feeder_pkg::DATA_SIZE,
    parameter int MAC_WIDTH = weight_feeder_pkg::MAC_WIDTH
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [MAC_WIDTH*DATA_SIZE-1:0]           row_data,
    input  logic                                     row_valid,
    output logic                                     row_ready,
    input  logic [MAC_WIDTH*MAC_WIDTH-1:0]           weights_request,
    output logic [MAC_WIDTH*MAC_WIDTH*DATA_SIZE-1:0] weights_data_in,
    output logic                                     weights_valid,
    output logic                                     weights_starved,
    output logic [15:0]                              tile_count
);

    import weight_feeder_pkg::*;

    localparam int PTR_W     = ptr_width(MAC_WIDTH);
    localparam int TILE_BITS = MAC_WIDTH * MAC_WIDTH * DATA_SIZE;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(MAC_WIDTH - 1);

    feed_state_e            state_q, state_d;
    logic [PTR_W-1:0]       row_ptr_q, row_ptr_d;
    logic [TILE_BITS-1:0]   active_q, active_d;
    logic [TILE_BITS-1:0]   load_tile;
    logic                   valid_q, valid_d;
    logic                   starved_q, starved_d;
    logic [15:0]            tile_count_q, tile_count_d;
    logic                   req_all;
    logic                   row_wr;
    logic                   swap;

    always_comb begin
        req_all      = &weights_request;
        row_wr       = (state_q == FILL) && row_valid;
        swap         = (state_q == FULL) && req_all;

        state_d      = state_q;
        row_ptr_d    = row_ptr_q;
        active_d     = active_q;
        tile_count_d = tile_count_q;
        valid_d      = swap;
        starved_d    = (state_q == FILL) && req_all;

        if (row_wr) begin
            row_ptr_d = row_ptr_q + PTR_W'(1);
            if (row_ptr_q == LAST_ROW) begin
                row_ptr_d = '0;
                state_d   = FULL;
            end
        end

        // Once swapped, the load buffer must be refilled before the next swap
        if (swap) begin
            active_d     = load_tile;
            tile_count_d = tile_count_q + 16'd1;
            state_d      = FILL;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            row_ptr_q    <= '0;
            active_q     <= '0;
            valid_q      <= 1'b0;
            starved_q    <= 1'b0;
            tile_count_q <= '0;
        end else begin
            state_q      <= state_d;
            row_ptr_q    <= row_ptr_d;
            active_q     <= active_d;
            valid_q      <= valid_d;
            starved_q    <= starved_d;
            tile_count_q <= tile_count_d;
        end
    end

    weight_row_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .MAC_WIDTH (MAC_WIDTH)
    ) u_load_buf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (row_wr),
        .wr_row   (row_ptr_q),
        .wr_data  (row_data),
        .tile_out (load_tile)
    );

    assign row_ready       = (state_q == FILL);
    assign weights_data_in = active_q;
    assign weights_valid   = valid_q;
    assign weights_starved = starved_q;
    assign tile_count      = tile_count_q;

endmodule

// File: tb/tb_weight_feeder.sv
// Bench for weight_feeder: constant vector table, directed corner sequences
// and randomized traffic against a tile-level reference model.
module tb_weight_feeder;

    localparam int DS     = 8;
    localparam int MW     = 8;
    localparam int ROW_W  = MW * DS;
    localparam int TILE_W = MW * MW * DS;
    localparam int REQ_W  = MW * MW;

    logic              clock;
    logic              reset;
    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;
    logic [REQ_W-1:0]  weights_request;
    logic [TILE_W-1:0] weights_data_in;
    logic              weights_valid;
    logic              weights_starved;
    logic [15:0]       tile_count;

    weight_feeder #(.DATA_SIZE(DS), .MAC_WIDTH(MW)) dut (
        .clock           (clock),
        .reset           (reset),
        .row_data        (row_data),
        .row_valid       (row_valid),
        .row_ready       (row_ready),
        .weights_request (weights_request),
        .weights_data_in (weights_data_in),
        .weights_valid   (weights_valid),
        .weights_starved (weights_starved),
        .tile_count      (tile_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] mk_row(input logic [7:0] base);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int c = 0; c < MW; c++) r[c*DS +: DS] = 8'(base + 8'(c));
        return r;
    endfunction

    function automatic logic [TILE_W-1:0] mk_tile(input logic [7:0] base);
        logic [TILE_W-1:0] t;
        t = '0;
        for (int r = 0; r < MW; r++)
            for (int c = 0; c < MW; c++)
                t[(r*MW+c)*DS +: DS] = 8'(base + 8'(r*MW + c));
        return t;
    endfunction

    function automatic logic [REQ_W-1:0] req_of(input logic [1:0] code);
        logic [REQ_W-1:0] q;
        q = '1;
        case (code)
            2'd0:    q = '0;
            2'd1:    q[0] = 1'b0;
            default: q = '1;
        endcase
        return q;
    endfunction

    // Reference model: tile-level view of the two buffers
    logic [TILE_W-1:0] m_load, m_active;
    int                m_loaded;
    logic              m_valid, m_starved;
    logic [15:0]       m_count;

    task automatic model_reset();
        m_load = '0; m_active = '0; m_loaded = 0;
        m_valid = 1'b0; m_starved = 1'b0; m_count = '0;
    endtask

    task automatic model_step(input logic rv, input logic [ROW_W-1:0] rd, input logic [REQ_W-1:0] rq);
        bit full, all_req;
        full      = (m_loaded == MW);
        all_req   = &rq;
        m_valid   = full && all_req;
        m_starved = !full && all_req;
        if (full && all_req) begin
            m_active = m_load;
            m_count  = m_count + 16'd1;
            m_loaded = 0;
        end else if (!full && rv) begin
            m_load[m_loaded*ROW_W +: ROW_W] = rd;
            m_loaded++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_row_ready"}, row_ready, m_loaded < MW);
        chk({tag, "_valid"}, weights_valid, m_valid);
        chk({tag, "_starved"}, weights_starved, m_starved);
        chk({tag, "_count"}, tile_count, m_count);
        chk({tag, "_data"}, weights_data_in, m_active);
    endtask

    // Called at posedge+1; inputs are held across the next edge
    task automatic drive(input string tag, input logic rv, input logic [ROW_W-1:0] rd, input logic [REQ_W-1:0] rq);
        row_valid = rv; row_data = rd; weights_request = rq;
        model_step(rv, rd, rq);
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        chk({tag, "_valid_in_rst"}, weights_valid, 1'b0);
        chk({tag, "_starved_in_rst"}, weights_starved, 1'b0);
        chk({tag, "_count_in_rst"}, tile_count, 16'd0);
        chk({tag, "_data_in_rst"}, weights_data_in, '0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk({tag, "_ready_after_rst"}, row_ready, 1'b1);
    endtask

    typedef struct {
        logic             rv;
        logic [ROW_W-1:0] rd;
        logic [1:0]       req;
        logic             ready;
        logic             valid;
        logic             starved;
        logic [15:0]      cnt;
        logic [1:0]       dchk;
        logic [7:0]       dbase;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic [ROW_W-1:0] rd, input logic [1:0] req,
                       input logic ready, input logic valid, input logic starved,
                       input logic [15:0] cnt, input logic [1:0] dchk, input logic [7:0] dbase);
        vec_t v;
        v.rv = rv; v.rd = rd; v.req = req; v.ready = ready; v.valid = valid;
        v.starved = starved; v.cnt = cnt; v.dchk = dchk; v.dbase = dbase;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        logic [REQ_W-1:0] rq;

        reset = 1'b1; row_valid = 1'b0; row_data = '0; weights_request = '0;
        model_reset();

        // Starved before any tile, first tile, partial request, ignored row in FULL
        add(1'b0, '0, 2'd2, 1'b1, 1'b0, 1'b1, 16'd0, 2'd1, 8'h00);
        for (int r = 0; r < MW; r++)
            add(1'b1, mk_row(8'(r*8)), 2'd2, r < MW-1, 1'b0, 1'b1, 16'd0, 2'd1, 8'h00);
        add(1'b0, '0, 2'd2, 1'b1, 1'b1, 1'b0, 16'd1, 2'd2, 8'h00);
        for (int r = 0; r < MW; r++)
            add(1'b1, mk_row(8'(8'h40 + r*8)), 2'd0, r < MW-1, 1'b0, 1'b0, 16'd1, 2'd2, 8'h00);
        add(1'b0, '0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1, 2'd2, 8'h00);
        add(1'b1, '1, 2'd1, 1'b0, 1'b0, 1'b0, 16'd1, 2'd2, 8'h00);
        add(1'b0, '0, 2'd2, 1'b1, 1'b1, 1'b0, 16'd2, 2'd2, 8'h40);
        add(1'b0, '0, 2'd2, 1'b1, 1'b0, 1'b1, 16'd2, 2'd2, 8'h40);

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("init_row_ready", row_ready, 1'b1);
        chk("init_valid", weights_valid, 1'b0);
        chk("init_starved", weights_starved, 1'b0);
        chk("init_count", tile_count, 16'd0);
        chk("init_data", weights_data_in, '0);

        foreach (vecs[i]) begin
            row_valid = vecs[i].rv; row_data = vecs[i].rd; weights_request = req_of(vecs[i].req);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_row_ready", i), row_ready, vecs[i].ready);
            chk($sformatf("vec%0d_valid", i), weights_valid, vecs[i].valid);
            chk($sformatf("vec%0d_starved", i), weights_starved, vecs[i].starved);
            chk($sformatf("vec%0d_count", i), tile_count, vecs[i].cnt);
            if (vecs[i].dchk == 2'd1) chk($sformatf("vec%0d_data", i), weights_data_in, '0);
            if (vecs[i].dchk == 2'd2) chk($sformatf("vec%0d_data", i), weights_data_in, mk_tile(vecs[i].dbase));
        end

        // Reset after a partial fill: stale rows must never reach the matrix
        async_reset("rst_tile");
        for (int r = 0; r < 5; r++) drive("partial", 1'b1, mk_row(8'(8'hA0 + r)), '0);
        async_reset("rst_partial");
        for (int r = 0; r < MW; r++) drive("fresh", 1'b1, mk_row(8'(8'h10 + r*8)), '0);
        drive("fresh_swap", 1'b0, '0, '1);
        chk("fresh_tile", weights_data_in, mk_tile(8'h10));

        // Back-to-back tiles with the request held high
        async_reset("rst_b2b");
        nvalid = 0;
        for (int i = 0; i < 3*(MW+1); i++) begin
            drive("b2b", 1'b1, {$urandom, $urandom}, '1);
            if (weights_valid) nvalid++;
        end
        chk("b2b_valid_pulses", 32'(nvalid), 32'd3);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rq = '1;
                4, 5, 6: begin
                    rq = {$urandom, $urandom};
                    rq[$urandom_range(0, REQ_W-1)] = 1'b0;
                end
                default: rq = '0;
            endcase
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
            else drive("rand", 1'($urandom_range(0, 1)), {$urandom, $urandom}, rq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
